uart_tx_engine: RTL and testbench
=================================

Name: uart_tx_engine

Overview:
Parametrised UART transmit engine that generalises the existing TX controller FSM. It combines frame sequencing, serializer, parity generation and a one-entry holding buffer in a single block. It supports configurable data width, even/odd parity, 1 or 2 stop bits, and gap-free back-to-back frames. It sits between the system-side data producer and the TX pin, advanced by a baud-rate bit_tick from the prescaler.

Parameters:
DATA_WIDTH, 8, payload bits per frame; legal range 5..9.
MSB_FIRST, 0, 0 = data transmitted LSB first; 1 = MSB first.

Ports:
CLK  input  1  system clock; all logic on rising edge.
RST  input  1  synchronous active-low reset; sampled on CLK rising edge.
P_DATA  input  DATA_WIDTH  parallel payload, captured when Data_Valid && ready.
Data_Valid  input  1  producer offers P_DATA.
ready  output  1  holding buffer empty; Data_Valid accepted this cycle when 1.
PAR_EN  input  1  parity bit enabled.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
STP2  input  1  0 = one stop bit, 1 = two stop bits.
bit_tick  input  1  one-cycle pulse per bit period.
TX_OUT  output  1  serial line, registered; idle high.
busy  output  1  frame in progress (state != IDLE).
frame_done  output  1  one-cycle pulse on the edge the last stop bit ends.

Behaviour:
- Reset (RST=0 at an edge): state = IDLE, TX_OUT = 1, busy = 0, ready = 1, frame_done = 0, hold buffer empty, bit counter = 0. Reset mid-frame abandons the frame; the line returns high on that same edge.
- Hold buffer:
  - On any edge with Data_Valid && ready, P_DATA is written to the hold register and hold_full is set. This is independent of bit_tick.
  - ready = !hold_full. Data_Valid while ready = 0 is ignored, with no overwrite.
  - hold_full clears on the edge the engine loads from it. ready rises the following cycle; there is no same-cycle pass-through.
- Engine advance: all state, counter and TX_OUT updates happen only on edges where bit_tick = 1. Each bit lasts exactly one tick interval.
- Frame load: the engine copies the hold register into the shift register and snapshots PAR_EN, PAR_TYP and STP2. These settings hold for the whole frame; changes mid-frame affect only later frames. Parity is computed at load time: even = XOR of the payload; odd = its inverse.
- States and transitions (evaluated at bit_tick):
  - IDLE: if hold_full, load and go to STR; else stay in IDLE.
  - STR: go to DATA, cnt = 0.
  - DATA: if cnt == DATA_WIDTH-1, go to PAR if parity is enabled, else STP1. Otherwise cnt++ and shift by one.
  - PAR: go to STP1.
  - STP1: if STP2 is set, go to STP2. Otherwise, if hold_full, load and go to STR (back-to-back); else go to IDLE.
  - STP2: if hold_full, load and go to STR; else go to IDLE.
- TX_OUT by state: IDLE = 1, STR = 0, DATA = current data bit, PAR = parity bit, STP1/STP2 = 1. TX_OUT is registered and changes on the same edge as the state.
- Frame length in ticks: 1 + DATA_WIDTH + PAR_EN + 1 + STP2.
- frame_done pulses on the tick edge that leaves the final stop state, including when going directly to STR.
- busy = 1 from the edge entering STR until the edge returning to IDLE.
- Data_Valid arriving in IDLE on the same edge as bit_tick is captured; the frame starts at the next tick.
- Unreachable state encodings go to IDLE with TX_OUT = 1 on the next edge.

Decomposition:
- Package uart_tx_pkg holds:
  - the state enum (IDLE, STR, DATA, PAR, STP1, STP2);
  - the line-level constants (START_BIT = 0, STOP_BIT = 1, IDLE_LEVEL = 1);
  - the parity-type encoding.
- One sub-module is natural: uart_tx_shift, containing the shift register, bit counter, parity calculation and last-bit flag. The FSM and hold buffer stay in uart_tx_engine.

Test Plan:
1. Reset: assert RST=0 during DATA bit 3 of a frame → next edge TX_OUT=1, busy=0, ready=1. No frame_done, and no further line activity with hold empty.
2. P_DATA=0xA5, PAR_EN=0, STP2=0, tick every 4 cycles → TX_OUT sequence 0,1,0,1,0,0,1,0,1,1 (10 ticks), one frame_done pulse, then busy=0.
3. P_DATA=0xA5 with PAR_EN=1: PAR_TYP=0 → parity bit 0; PAR_TYP=1 → parity bit 1. Each frame lasts 11 ticks.
4. STP2=1, PAR_EN=1, P_DATA=0x3C → 12-tick frame ending in two high stop bits. frame_done fires only after the second stop bit.
5. Back-to-back: push 0x55 then 0x0F while busy → second start bit immediately follows the first frame's stop bit with no idle bit. A third Data_Valid while ready=0 is dropped; only two frames appear.
6. Toggle PAR_EN 0→1 and STP2 0→1 during DATA of frame 1 → frame 1 stays 10 ticks; frame 2 (already queued) uses the new settings (12 ticks).

Source files
------------

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared FSM states, line levels and parity encoding for the UART transmitter
package uart_tx_pkg;
    typedef enum logic [2:0] {IDLE, STR, DATA, PAR, STP1, STP2} state_t;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;
    typedef enum logic {PAR_EVEN = 1'b0, PAR_ODD = 1'b1} par_t;
endpackage

// File: rtl/uart_tx_shift.sv
// uart_tx_shift: payload shift register, bit counter, parity and last-bit flag
// Ports: clk/rst_n (sync active-low), load copies data and computes parity,
// shift advances one bit; cur_bit/next_bit are the bit on the line now and after a shift,
// par_bit is the frame's parity, last flags the final payload bit.
module uart_tx_shift #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  cur_bit,
    output logic                  next_bit,
    output logic                  par_bit,
    output logic                  last
);
    import uart_tx_pkg::*;
    localparam int CW = $clog2(DATA_WIDTH);
    logic [DATA_WIDTH-1:0] sr;
    logic [CW-1:0]         cnt;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr      <= '0;
            cnt     <= '0;
            par_bit <= 1'b0;
        end else if (load) begin
            sr      <= data;
            cnt     <= '0;
            par_bit <= (^data) ^ (par_t'(par_typ) == PAR_ODD);
        end else if (shift) begin
            sr  <= MSB_FIRST ? {sr[DATA_WIDTH-2:0], 1'b0} : {1'b0, sr[DATA_WIDTH-1:1]};
            cnt <= cnt + 1'b1;
        end
    end
    assign cur_bit  = MSB_FIRST ? sr[DATA_WIDTH-1] : sr[0];
    // TX_OUT is registered, so the bit that will be on the line after a shift is needed one edge early
    assign next_bit = MSB_FIRST ? sr[DATA_WIDTH-2] : sr[1];
    assign last     = cnt == CW'(DATA_WIDTH - 1);
endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: UART transmit FSM with one-entry holding buffer, parity and 1/2 stop bits
// Ports: CLK, RST (sync active-low); P_DATA/Data_Valid/ready producer handshake;
// PAR_EN/PAR_TYP/STP2 frame settings (snapshotted at load); bit_tick baud strobe;
// TX_OUT registered serial line; busy while a frame runs; frame_done after the last stop bit.
module uart_tx_engine #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    output logic                  ready,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STP2,
    input  logic                  bit_tick,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  frame_done
);
    import uart_tx_pkg::*;
    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] hold;
    logic                  hold_full, par_en_q, stp2_q;
    logic                  load, shift, done, tx_n;
    logic                  cur_bit, next_bit, par_bit, last;

    uart_tx_shift #(.DATA_WIDTH(DATA_WIDTH), .MSB_FIRST(MSB_FIRST)) u_shift (
        .clk(CLK), .rst_n(RST), .load(load), .shift(shift), .data(hold), .par_typ(PAR_TYP),
        .cur_bit(cur_bit), .next_bit(next_bit), .par_bit(par_bit), .last(last)
    );

    assign ready = !hold_full;
    assign busy  = state != IDLE;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= IDLE;
            TX_OUT     <= IDLE_LEVEL;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            TX_OUT     <= tx_n;
            frame_done <= done;
        end
    end

    // Loading and capturing are mutually exclusive: load needs a full buffer, capture an empty one
    always_ff @(posedge CLK) begin
        if (!RST) begin
            hold      <= '0;
            hold_full <= 1'b0;
            par_en_q  <= 1'b0;
            stp2_q    <= 1'b0;
        end else if (load) begin
            hold_full <= 1'b0;
            par_en_q  <= PAR_EN;
            stp2_q    <= STP2;
        end else if (Data_Valid && !hold_full) begin
            hold      <= P_DATA;
            hold_full <= 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        shift   = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: if (bit_tick && hold_full) begin
                load    = 1'b1;
                state_n = STR;
            end
            STR:  if (bit_tick) state_n = DATA;
            DATA: if (bit_tick) begin
                if (last) state_n = par_en_q ? PAR : STP1;
                else shift = 1'b1;
            end
            PAR:  if (bit_tick) state_n = STP1;
            STP1: if (bit_tick) begin
                if (stp2_q) state_n = uart_tx_pkg::STP2;
                else begin
                    done    = 1'b1;
                    load    = hold_full;
                    state_n = hold_full ? STR : IDLE;
                end
            end
            uart_tx_pkg::STP2: if (bit_tick) begin
                done    = 1'b1;
                load    = hold_full;
                state_n = hold_full ? STR : IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Every line change coincides with a state change, except data bits advancing within DATA
        tx_n = (state_n == state && !shift) ? TX_OUT :
               state_n == STR  ? START_BIT :
               state_n == DATA ? (shift ? next_bit : cur_bit) :
               state_n == PAR  ? par_bit :
               state_n == IDLE ? IDLE_LEVEL : STOP_BIT;
    end
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: table-driven, directed and randomized checks against a frame-level model
module tb_uart_tx_engine;
    logic       CLK = 1'b0, RST = 1'b0, Data_Valid = 1'b0, PAR_EN = 1'b0, PAR_TYP = 1'b0, STP2 = 1'b0, bit_tick = 1'b0;
    logic [7:0] P_DATA = '0;
    logic       ready, TX_OUT, busy, frame_done;
    int         checks = 0, errors = 0, div = 0, done_cnt = 0;
    bit         line_q[$], exp_q[$];

    uart_tx_engine #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid), .ready(ready),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STP2(STP2), .bit_tick(bit_tick),
        .TX_OUT(TX_OUT), .busy(busy), .frame_done(frame_done)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        div = (div + 1) % 4;
        bit_tick = (div == 0);
    end

    // Records the line level after every tick edge while a frame is in progress
    always @(posedge CLK) begin : mon
        logic t;
        t = bit_tick;
        #1;
        if (frame_done) done_cnt++;
        if (t && RST && busy) line_q.push_back(TX_OUT);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame model: start, payload LSB first, optional parity, one or two stop bits
    task automatic add_frame(input logic [7:0] d, input bit pe, input bit pt, input bit s2);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (pe) exp_q.push_back((^d) ^ pt);
        exp_q.push_back(1'b1);
        if (s2) exp_q.push_back(1'b1);
    endtask

    task automatic cmp_seq(input string name);
        int bad = -1;
        chk({name, "_len"}, line_q.size(), exp_q.size());
        for (int i = 0; i < line_q.size() && i < exp_q.size(); i++)
            if (line_q[i] !== exp_q[i] && bad < 0) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s_bits: bit %0d got %0b expected %0b", name, bad, line_q[bad], exp_q[bad]);
        end
    endtask

    task automatic send(input logic [7:0] d);
        int n = 0;
        while (!ready && n < 400) begin
            @(negedge CLK);
            n++;
        end
        chk("ready_before_send", ready, 1);
        P_DATA = d;
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!busy && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("busy_rise", busy, 1);
    endtask

    task automatic wait_done(input int target, output int sz);
        int n = 0;
        while (done_cnt < target && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        chk("frame_done_seen", done_cnt >= target, 1);
        sz = line_q.size();
    endtask

    task automatic settings(input bit pe, input bit pt, input bit s2);
        PAR_EN = pe;
        PAR_TYP = pt;
        STP2 = s2;
    endtask

    typedef struct {
        logic [7:0] d;
        bit         pe, pt, s2;
        int         len;
        bit         par;
    } vec_t;
    vec_t tbl[8];

    initial begin
        int d0, sz, n;
        logic [9:0] v;
        logic [7:0] d1, d2;
        bit pe1, pt1, s21, pe2, pt2, s22;
        tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 10, 1'b0};
        tbl[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 11, 1'b0};
        tbl[2] = '{8'hA5, 1'b1, 1'b1, 1'b0, 11, 1'b1};
        tbl[3] = '{8'h3C, 1'b1, 1'b0, 1'b1, 12, 1'b0};
        tbl[4] = '{8'hFF, 1'b1, 1'b0, 1'b0, 11, 1'b0};
        tbl[5] = '{8'h01, 1'b1, 1'b1, 1'b1, 12, 1'b0};
        tbl[6] = '{8'h80, 1'b1, 1'b0, 1'b0, 11, 1'b1};
        tbl[7] = '{8'h00, 1'b0, 1'b0, 1'b1, 11, 1'b0};

        repeat (3) @(negedge CLK);
        chk("rst_tx", TX_OUT, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ready", ready, 1);
        chk("rst_done", frame_done, 0);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        for (int i = 0; i < 8; i++) begin
            settings(tbl[i].pe, tbl[i].pt, tbl[i].s2);
            line_q.delete();
            exp_q.delete();
            d0 = done_cnt;
            add_frame(tbl[i].d, tbl[i].pe, tbl[i].pt, tbl[i].s2);
            send(tbl[i].d);
            wait_done(d0 + 1, sz);
            chk($sformatf("tbl%0d_len_at_done", i), sz, tbl[i].len);
            if (tbl[i].pe) chk($sformatf("tbl%0d_parity", i), line_q.size() > 9 ? line_q[9] : 1'bx, tbl[i].par);
            if (i == 0) begin
                for (int k = 0; k < 10; k++) v[9-k] = k < line_q.size() ? line_q[k] : 1'bx;
                chk("a5_sequence", v, 10'b0101001011);
            end
            repeat (8) @(negedge CLK);
            chk($sformatf("tbl%0d_idle_busy", i), busy, 0);
            chk($sformatf("tbl%0d_idle_ready", i), ready, 1);
            chk($sformatf("tbl%0d_done_pulses", i), done_cnt - d0, 1);
            cmp_seq($sformatf("tbl%0d", i));
        end

        settings(0, 0, 0);
        line_q.delete();
        exp_q.delete();
        d0 = done_cnt;
        add_frame(8'h55, 0, 0, 0);
        add_frame(8'h0F, 0, 0, 0);
        send(8'h55);
        wait_busy();
        send(8'h0F);
        chk("b2b_ready_full", ready, 0);
        P_DATA = 8'h33;
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        wait_done(d0 + 1, sz);
        chk("b2b_busy_at_done", busy, 1);
        chk("b2b_len_at_first_done", sz, 11);
        wait_done(d0 + 2, sz);
        repeat (120) @(negedge CLK);
        chk("b2b_done_pulses", done_cnt - d0, 2);
        cmp_seq("b2b");

        settings(0, 0, 0);
        line_q.delete();
        exp_q.delete();
        d0 = done_cnt;
        add_frame(8'h96, 0, 0, 0);
        add_frame(8'h3C, 1, 0, 1);
        send(8'h96);
        wait_busy();
        send(8'h3C);
        n = 0;
        while (line_q.size() < 4 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        settings(1, 0, 1);
        wait_done(d0 + 1, sz);
        chk("midchg_len_first", sz, 11);
        wait_done(d0 + 2, sz);
        chk("midchg_len_total", sz, 22);
        repeat (8) @(negedge CLK);
        cmp_seq("midchg");

        settings(0, 0, 0);
        line_q.delete();
        d0 = done_cnt;
        send(8'h00);
        wait_busy();
        send(8'h00);
        n = 0;
        while (line_q.size() < 5 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("pre_reset_line", TX_OUT, 0);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        chk("mid_rst_tx", TX_OUT, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_done", frame_done, 0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (80) @(negedge CLK);
        chk("post_rst_no_bits", line_q.size(), 5);
        chk("post_rst_no_done", done_cnt, d0);
        chk("post_rst_tx", TX_OUT, 1);

        for (int i = 0; i < 20; i++) begin
            d1 = 8'($urandom);
            d2 = 8'($urandom);
            {pe1, pt1, s21, pe2, pt2, s22} = 6'($urandom);
            line_q.delete();
            exp_q.delete();
            d0 = done_cnt;
            add_frame(d1, pe1, pt1, s21);
            add_frame(d2, pe2, pt2, s22);
            settings(pe1, pt1, s21);
            send(d1);
            wait_busy();
            settings(pe2, pt2, s22);
            send(d2);
            wait_done(d0 + 2, sz);
            repeat (8) @(negedge CLK);
            chk($sformatf("rnd%0d_done_pulses", i), done_cnt - d0, 2);
            cmp_seq($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
